// File: rtl/rx_frame_assembler.sv
// Serial receive framer: strips start/stop bits, assembles a FRAME_BITS frame into a one-entry
// valid/ready output buffer, and reports framing errors and overruns with saturating counters.
module rx_frame_assembler #(
  parameter int FRAME_BITS = 55,
  parameter int ERR_CNT_W  = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  rx_bit,
  input  logic                  rx_ready,
  output logic [FRAME_BITS-1:0] RX_Data,
  output logic                  rx_valid,
  output logic                  framing_err,
  output logic                  overrun,
  output logic [ERR_CNT_W-1:0]  framing_err_cnt,
  output logic [ERR_CNT_W-1:0]  overrun_cnt
);

  typedef enum logic [1:0] {IDLE, DATA, STOP} state_t;

  state_t                state, state_nxt;
  logic [5:0]            bit_cnt;
  logic [FRAME_BITS-1:0] shreg;
  logic                  last_bit;
  logic                  load, drop_full, bad_stop, drain;

  assign last_bit = (bit_cnt == 6'(FRAME_BITS - 1));

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (!rx_bit) state_nxt = DATA;
      DATA:    if (last_bit) state_nxt = STOP;
      STOP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // A drain in the stop cycle frees the buffer in time for the new frame.
  always_comb begin
    drain     = rx_valid && rx_ready;
    load      = 1'b0;
    drop_full = 1'b0;
    bad_stop  = 1'b0;
    if (state == STOP) begin
      if (rx_bit) begin
        load      = !rx_valid || rx_ready;
        drop_full = rx_valid && !rx_ready;
      end else begin
        bad_stop  = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      bit_cnt <= '0;
      shreg   <= '0;
    end else begin
      case (state)
        IDLE: if (!rx_bit) bit_cnt <= '0;
        DATA: begin
          shreg   <= {shreg[FRAME_BITS-2:0], rx_bit};
          bit_cnt <= bit_cnt + 6'd1;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      RX_Data         <= '0;
      rx_valid        <= 1'b0;
      framing_err     <= 1'b0;
      overrun         <= 1'b0;
      framing_err_cnt <= '0;
      overrun_cnt     <= '0;
    end else begin
      framing_err <= bad_stop;
      overrun     <= drop_full;
      if (load) begin
        RX_Data  <= shreg;
        rx_valid <= 1'b1;
      end else if (drain) begin
        rx_valid <= 1'b0;
      end
      if (bad_stop && framing_err_cnt != '1)
        framing_err_cnt <= framing_err_cnt + ERR_CNT_W'(1);
      if (drop_full && overrun_cnt != '1)
        overrun_cnt <= overrun_cnt + ERR_CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_rx_frame_assembler.sv
// Bench for rx_frame_assembler: directed and random frames against a transaction-level model.
module tb_rx_frame_assembler;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        rx_bit = 1'b1;
  logic        rx_ready = 1'b0;

  logic [54:0] RX_Data, RX_Data_s;
  logic        rx_valid, framing_err, overrun;
  logic        rx_valid_s, framing_err_s, overrun_s;
  logic [7:0]  fcnt, ocnt;
  logic [1:0]  fcnt_s, ocnt_s;

  always #5 clk = ~clk;

  rx_frame_assembler dut (
    .clk(clk), .rst(rst), .rx_bit(rx_bit), .rx_ready(rx_ready),
    .RX_Data(RX_Data), .rx_valid(rx_valid), .framing_err(framing_err), .overrun(overrun),
    .framing_err_cnt(fcnt), .overrun_cnt(ocnt)
  );

  rx_frame_assembler #(.FRAME_BITS(55), .ERR_CNT_W(2)) dut_sat (
    .clk(clk), .rst(rst), .rx_bit(rx_bit), .rx_ready(rx_ready),
    .RX_Data(RX_Data_s), .rx_valid(rx_valid_s), .framing_err(framing_err_s), .overrun(overrun_s),
    .framing_err_cnt(fcnt_s), .overrun_cnt(ocnt_s)
  );

  int errors = 0;
  int checks = 0;

  // Reference model state: what the buffer and counters should hold.
  logic [54:0] m_data;
  logic        m_valid, e_ferr, e_ovr;
  int          m_fcnt, m_ocnt;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s @%0t: got %0h expected %0h", tag, $time, got, exp);
    end
  endtask

  function automatic int sat(input int v, input int mx);
    return (v > mx) ? mx : v;
  endfunction

  task automatic tick(input logic b, input logic rdy, input logic is_stop, input logic [54:0] frm);
    rx_bit = b;
    rx_ready = rdy;
    @(posedge clk);
    e_ferr = 1'b0;
    e_ovr  = 1'b0;
    if (rst) begin
      m_valid = 1'b0; m_data = '0; m_fcnt = 0; m_ocnt = 0;
    end else if (is_stop && b && (!m_valid || rdy)) begin
      m_data = frm; m_valid = 1'b1;
    end else begin
      if (m_valid && rdy) m_valid = 1'b0;
      if (is_stop && b)  begin e_ovr = 1'b1;  m_ocnt++; end
      if (is_stop && !b) begin e_ferr = 1'b1; m_fcnt++; end
    end
    #1;
    check("rx_valid", 64'(rx_valid), 64'(m_valid));
    check("RX_Data", 64'(RX_Data), 64'(m_data));
    check("framing_err", 64'(framing_err), 64'(e_ferr));
    check("overrun", 64'(overrun), 64'(e_ovr));
    check("framing_err_cnt", 64'(fcnt), 64'(sat(m_fcnt, 255)));
    check("overrun_cnt", 64'(ocnt), 64'(sat(m_ocnt, 255)));
    check("sat_framing_err", 64'(framing_err_s), 64'(e_ferr));
    check("sat_framing_err_cnt", 64'(fcnt_s), 64'(sat(m_fcnt, 3)));
    check("sat_overrun_cnt", 64'(ocnt_s), 64'(sat(m_ocnt, 3)));
  endtask

  function automatic logic pick_rdy(input int rmode);
    return (rmode != 0) ? 1'($urandom_range(0, 1)) : 1'b0;
  endfunction

  task automatic idle(input int n, input int rmode, input logic rdy);
    for (int i = 0; i < n; i++)
      tick(1'b1, (rmode != 0) ? pick_rdy(rmode) : rdy, 1'b0, '0);
  endtask

  // rmode 0: rx_ready low except srdy in the stop cycle; rmode 1: random every cycle.
  task automatic send(input logic [54:0] d, input logic stop, input int rmode, input logic srdy);
    tick(1'b0, pick_rdy(rmode), 1'b0, '0);
    for (int i = 54; i >= 0; i--)
      tick(d[i], pick_rdy(rmode), 1'b0, '0);
    tick(stop, (rmode != 0) ? pick_rdy(rmode) : srdy, 1'b1, d);
  endtask

  function automatic logic [54:0] rand_frame();
    logic [63:0] r;
    r = {$urandom, $urandom};
    return r[54:0];
  endfunction

  initial begin
    logic [54:0] d;
    m_data = '0; m_valid = 1'b0; m_fcnt = 0; m_ocnt = 0;

    rst = 1'b1;
    idle(2, 0, 1'b0);
    rst = 1'b0;
    idle(100, 0, 1'b0);

    send(55'h289f05acb00000, 1'b1, 0, 1'b0);
    idle(5, 0, 1'b0);
    idle(1, 0, 1'b1);
    idle(3, 0, 1'b0);

    send(rand_frame(), 1'b0, 0, 1'b0);
    idle(3, 0, 1'b0);
    send(55'h0abcdef1234567, 1'b1, 0, 1'b0);
    idle(2, 0, 1'b1);

    send(55'h1, 1'b1, 0, 1'b0);
    send(55'h2, 1'b1, 0, 1'b0);
    idle(3, 0, 1'b0);
    idle(1, 0, 1'b1);
    send(55'h1, 1'b1, 0, 1'b0);
    send(55'h2, 1'b1, 0, 1'b1);
    idle(3, 0, 1'b0);
    idle(2, 0, 1'b1);

    d = 55'h5555555555555;
    tick(1'b0, 1'b0, 1'b0, '0);
    for (int i = 54; i > 25; i--) tick(d[i], 1'b0, 1'b0, '0);
    rst = 1'b1;
    tick(1'b1, 1'b0, 1'b0, '0);
    rst = 1'b0;
    idle(3, 0, 1'b0);
    send(55'h7FFFFFFFFFFFFF, 1'b1, 0, 1'b0);
    idle(3, 0, 1'b0);
    idle(2, 0, 1'b1);

    for (int k = 0; k < 5; k++) begin
      send(rand_frame(), 1'b0, 1, 1'b0);
      idle(1, 1, 1'b0);
    end

    for (int k = 0; k < 40; k++) begin
      send(rand_frame(), 1'($urandom_range(0, 7) != 0), 1, 1'b0);
      idle($urandom_range(0, 3), 1, 1'b0);
    end
    idle(4, 0, 1'b1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
